// File: rtl/conv55_feeder.sv
// conv55_feeder: raster-to-column streamer for a 5x5 convolution window.
// Keeps four previous image rows in line buffers and emits one 5-pixel
// column slice (top row first) per accepted pixel, with window tracking.
module conv55_feeder #(
  parameter int BIT_WIDTH = 8,
  parameter int IMG_W     = 32,
  parameter int IMG_H     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [BIT_WIDTH-1:0] s_data,
  input  logic                 stall,
  output logic                 en,
  output logic [BIT_WIDTH-1:0] out1,
  output logic [BIT_WIDTH-1:0] out2,
  output logic [BIT_WIDTH-1:0] out3,
  output logic [BIT_WIDTH-1:0] out4,
  output logic [BIT_WIDTH-1:0] out5,
  output logic                 win_valid,
  output logic                 frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic                 accept;
  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic [CW-1:0]        c_iss_q, c_iss_d;
  logic [RW-1:0]        r_iss_q, r_iss_d;
  logic                 en_q, en_d;
  logic                 win_valid_q, win_valid_d;
  logic                 frame_done_q, frame_done_d;
  logic [BIT_WIDTH-1:0] out1_q, out1_d, out2_q, out2_d, out3_q, out3_d;
  logic [BIT_WIDTH-1:0] out4_q, out4_d, out5_q, out5_d;

  // Line buffers: lb0 = row r-1 ... lb3 = row r-4, indexed by column.
  logic [BIT_WIDTH-1:0] lb0_q [IMG_W];
  logic [BIT_WIDTH-1:0] lb1_q [IMG_W];
  logic [BIT_WIDTH-1:0] lb2_q [IMG_W];
  logic [BIT_WIDTH-1:0] lb3_q [IMG_W];
  logic [BIT_WIDTH-1:0] lb0_rd, lb1_rd, lb2_rd, lb3_rd;

  assign s_ready = rst_n && !stall;
  assign accept  = s_valid && s_ready;

  assign lb0_rd = lb0_q[col_q];
  assign lb1_rd = lb1_q[col_q];
  assign lb2_rd = lb2_q[col_q];
  assign lb3_rd = lb3_q[col_q];

  // Raster position of the next pixel; wraps seamlessly into the next frame.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Slice issue, issued-coordinate capture and window flags.
  always_comb begin
    en_d    = accept;
    out1_d  = out1_q;
    out2_d  = out2_q;
    out3_d  = out3_q;
    out4_d  = out4_q;
    out5_d  = out5_q;
    r_iss_d = r_iss_q;
    c_iss_d = c_iss_q;
    if (accept) begin
      out5_d  = s_data;
      out4_d  = lb0_rd;
      out3_d  = lb1_rd;
      out2_d  = lb2_rd;
      out1_d  = lb3_rd;
      r_iss_d = row_q;
      c_iss_d = col_q;
    end
    win_valid_d  = en_q && (r_iss_q >= RW'(4)) && (c_iss_q >= CW'(4));
    frame_done_d = en_q && (r_iss_q == RW'(IMG_H - 1)) && (c_iss_q == CW'(IMG_W - 1));
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      r_iss_q      <= '0;
      c_iss_q      <= '0;
      en_q         <= 1'b0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out1_q       <= '0;
      out2_q       <= '0;
      out3_q       <= '0;
      out4_q       <= '0;
      out5_q       <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      r_iss_q      <= r_iss_d;
      c_iss_q      <= c_iss_d;
      en_q         <= en_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      out1_q       <= out1_d;
      out2_q       <= out2_d;
      out3_q       <= out3_d;
      out4_q       <= out4_d;
      out5_q       <= out5_d;
    end
  end

  // Line-buffer shift per column; reads above see the pre-write contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb3_q[col_q] <= lb2_rd;
      lb2_q[col_q] <= lb1_rd;
      lb1_q[col_q] <= lb0_rd;
      lb0_q[col_q] <= s_data;
    end
  end

  assign en         = en_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign out1       = out1_q;
  assign out2       = out2_q;
  assign out3       = out3_q;
  assign out4       = out4_q;
  assign out5       = out5_q;

endmodule

// File: tb/tb_conv55_feeder.sv
// Directed self-checking bench for conv55_feeder (32x32, 8-bit).
module tb_conv55_feeder;

  logic       clk = 1'b0;
  logic       rst_n, s_valid, s_ready, stall, en, win_valid, frame_done;
  logic [7:0] s_data, out1, out2, out3, out4, out5;

  int n_checks = 0;
  int n_err    = 0;

  // Bench-side reference state
  int mr = 0, mc = 0;
  logic last_acc = 1'b0;
  int last_r = 0, last_c = 0;
  int wv_seen = 0, fd_seen = 0;
  logic corner_en = 1'b0;

  conv55_feeder #(.BIT_WIDTH(8), .IMG_W(32), .IMG_H(32)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .stall(stall), .en(en),
    .out1(out1), .out2(out2), .out3(out3), .out4(out4), .out5(out5),
    .win_valid(win_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pixval(input int r, input int c);
    return 8'((r * 32 + c) % 256);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check s_ready, then check registered outputs.
  task automatic step(input logic v, input logic st, input logic rn);
    logic acc;
    int ir, ic;
    logic [7:0] o [5];
    logic exp_wv, exp_fd;
    rst_n   = rn;
    s_valid = v;
    stall   = st;
    s_data  = pixval(mr, mc);
    #1;
    check("s_ready", 32'(s_ready), 32'(rn && !st));
    acc = v && rn && !st;
    ir = mr;
    ic = mc;
    @(posedge clk);
    #1;
    o[0] = out1; o[1] = out2; o[2] = out3; o[3] = out4; o[4] = out5;
    exp_wv = rn && last_acc && last_r >= 4 && last_c >= 4;
    exp_fd = rn && last_acc && last_r == 31 && last_c == 31;
    check("en", 32'(en), 32'(acc));
    check("win_valid", 32'(win_valid), 32'(exp_wv));
    check("frame_done", 32'(frame_done), 32'(exp_fd));
    if (win_valid === 1'b1) wv_seen++;
    if (frame_done === 1'b1) fd_seen++;
    if (!rn) begin
      for (int k = 0; k < 5; k++) check($sformatf("rst_out%0d", k + 1), 32'(o[k]), 32'd0);
    end else if (acc) begin
      for (int k = 0; k < 5; k++)
        if (ir - 4 + k >= 0)
          check($sformatf("out%0d r%0d c%0d", k + 1, ir, ic), 32'(o[k]), 32'(pixval(ir - 4 + k, ic)));
      if (corner_en && ir == 4 && ic == 4) begin
        check("corner_out1", 32'(out1), 32'd4);
        check("corner_out2", 32'(out2), 32'd36);
        check("corner_out3", 32'(out3), 32'd68);
        check("corner_out4", 32'(out4), 32'd100);
        check("corner_out5", 32'(out5), 32'd132);
      end
      if (corner_en && ir == 5 && ic == 4) begin
        check("row5_out1", 32'(out1), 32'd36);
        check("row5_out2", 32'(out2), 32'd68);
        check("row5_out3", 32'(out3), 32'd100);
        check("row5_out4", 32'(out4), 32'd132);
        check("row5_out5", 32'(out5), 32'd164);
      end
    end
    if (!rn) begin
      mr = 0;
      mc = 0;
      last_acc = 1'b0;
    end else begin
      last_acc = acc;
      last_r = ir;
      last_c = ic;
      if (acc) begin
        if (mc == 31) begin
          mc = 0;
          mr = (mr == 31) ? 0 : mr + 1;
        end else begin
          mc = mc + 1;
        end
      end
    end
  endtask

  // Push n pixels with random stalls/gaps, bounded by a cycle budget.
  task automatic stream(input int n, input int stall_pct, input int gap_pct);
    int sent = 0;
    int cyc  = 0;
    logic st, v;
    while (sent < n && cyc < 20 * n + 100) begin
      st = ($urandom_range(0, 99) < stall_pct);
      v  = !($urandom_range(0, 99) < gap_pct);
      step(v, st, 1'b1);
      if (v && !st) sent++;
      cyc++;
    end
    check("stream_budget", 32'(sent), 32'(n));
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b1; stall = 1'b0; s_data = '0;

    // Reset held three cycles with s_valid high
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);

    // Single unstalled frame with explicit corner/row-edge values
    corner_en = 1'b1;
    wv_seen = 0; fd_seen = 0;
    stream(1024, 0, 0);
    drain();
    check("frame1_windows", 32'(wv_seen), 32'd784);
    check("frame1_done", 32'(fd_seen), 32'd1);
    corner_en = 1'b0;

    // Same frame with random stalls and valid gaps
    wv_seen = 0; fd_seen = 0;
    stream(1024, 30, 20);
    drain();
    check("stall_windows", 32'(wv_seen), 32'd784);
    check("stall_done", 32'(fd_seen), 32'd1);

    // Back-to-back frames with no gap
    wv_seen = 0; fd_seen = 0;
    stream(2048, 0, 0);
    drain();
    check("b2b_windows", 32'(wv_seen), 32'd1568);
    check("b2b_done", 32'(fd_seen), 32'd2);

    // Reset pulse mid-frame at row 10, then a full frame
    stream(320, 0, 0);
    step(1'b1, 1'b0, 1'b0);
    corner_en = 1'b1;
    wv_seen = 0; fd_seen = 0;
    stream(1024, 0, 0);
    drain();
    check("midrst_windows", 32'(wv_seen), 32'd784);
    check("midrst_done", 32'(fd_seen), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/conv55_feeder.md
# conv55_feeder

Raster-to-column streamer that drives the 5x5 convolution window. It accepts one feature-map pixel per cycle in raster order and keeps the previous four image rows in line buffers. For every accepted pixel it issues one 5-pixel column slice, top row to bottom row, with a shift enable to the downstream 5x5 window/MAC stage. It also flags the cycles in which the downstream window holds a complete, in-bounds 5x5 neighbourhood.

## Interface
- BIT_WIDTH, 8: pixel width, signed two's complement.
- IMG_W, 32: feature-map width in pixels, must be at least 5.
- IMG_H, 32: feature-map height in pixels, must be at least 5.
- clk  in  1: single clock; all logic on its rising edge.
- rst_n  in  1: synchronous, active-low reset.
- s_valid  in  1: input pixel valid.
- s_ready  out  1: input pixel ready; a pixel transfers on s_valid && s_ready.
- s_data  in  BIT_WIDTH: input pixel, raster order, row-major.
- stall  in  1: downstream hold; blocks acceptance while high.
- en  out  1: shift enable for the downstream window.
- out1..out5  out  BIT_WIDTH each: column slice; out1 = row r-4 (top), out5 = row r (current).
- win_valid  out  1: downstream window is a complete 5x5 neighbourhood this cycle.
- frame_done  out  1: one-cycle pulse on the last window of a frame.

## Operation
- s_ready = rst_n && !stall, combinational. accept = s_valid && s_ready.
- Position counters col (0..IMG_W-1) and row (0..IMG_H-1), each $clog2 wide, hold the coordinates of the next pixel.
  - On accept, col increments.
  - At IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0. The next pixel starts a new frame with no gap or idle state.
- Line buffers lb0..lb3, each IMG_W x BIT_WIDTH, indexed by col. lb0 holds row r-1, lb3 holds row r-4.
- On accept at (r,c):
  - Register outputs: out5 <= s_data, out4 <= lb0[c], out3 <= lb1[c], out2 <= lb2[c], out1 <= lb3[c]; en <= 1.
  - Write back in the same cycle: lb3[c] <= lb2[c], lb2[c] <= lb1[c], lb1[c] <= lb0[c], lb0[c] <= s_data. This is a read-before-write per column.
- On no accept: en <= 0 and out1..out5 hold their values.
- Line buffers are not reset. Slices issued for r<4 carry don't-care upper rows; win_valid masks them.
- Window tracking:
  - Register the issued coordinate (r,c) alongside en.
  - win_valid <= en && r_issued >= 4 && c_issued >= 4.
  - frame_done <= en && r_issued == IMG_H-1 && c_issued == IMG_W-1.
- Windows exist only within a row. Slices for c = 0..3 of any row never raise win_valid, so left-edge columns flush stale data from the previous row.
- Windows per frame: (IMG_H-4)*(IMG_W-4), which is 784 for 32x32.

## Timing
- Reset values:
  - en, win_valid, frame_done, out1..out5 = 0.
  - col = row = 0.
  - s_ready follows !stall once rst_n = 1.
- Reset mid-frame discards position: the first pixel accepted after release is (0,0). The line buffers keep stale data, which is masked by the r<4 rule.
- Latency:
  - Accept in cycle T gives en and the slice in cycle T+1.
  - The downstream window latches at the end of T+1.
  - win_valid and frame_done are high in cycle T+2, aligned with the downstream combinational sum.
- stall high in cycle T: no accept in T, so en = 0 in T+1. A stall inserts bubbles only; the slice sequence is identical to an unstalled run.
- s_valid low behaves like a stall.
- The frame wrap and a new frame's first pixel may occur in consecutive cycles. frame_done for frame N and the slices of frame N+1 may overlap without interaction.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with s_valid=1 -> en, win_valid, frame_done and out1..out5 are 0 and no counters advance. Release with stall=0 -> s_ready=1.
- Single 32x32 frame, pixel = (r*32+c) mod 256, no stall:
  - The en cycle for pixel (4,4) shows out1..out5 = 4, 36, 68, 100, 132.
  - win_valid goes high the next cycle.
  - Exactly 784 win_valid pulses occur, and frame_done coincides with the last one.
- Same frame with random 30% stall and random s_valid gaps -> the en-qualified slice sequence matches the unstalled run bit-for-bit, with 784 windows.
- Row edge: during row 5, slices for c = 0..3 have win_valid=0, and c=4 gives win_valid=1 with out1..out5 = (1,4)..(5,4) = 36, 68, 100, 132, 164.
- Back-to-back frames with no gap -> the first window of frame 2 comes only after its pixel (4,4). There are 784 pulses per frame and 2 frame_done pulses.
- rst_n asserted for one cycle at row 10 mid-frame, then a full frame is streamed -> exactly 784 windows and one frame_done, and the first window slice equals the values for (0..4, 4).
